// File: rtl/riscv_pkg.sv
// Shared opcode constants and immediate-format encoding for the decode stage.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_R      = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

endpackage

// File: rtl/sign_ext.sv
// Immediate extender: rebuilds the 32-bit immediate from instruction bits [31:7].
module sign_ext
    import riscv_pkg::*;
(
    input  logic [24:0] Imm,
    input  imm_src_t    ImmSrc,
    output logic [31:0] ImmExt
);

    // Imm[k] corresponds to instruction bit k+7.
    always_comb begin
        ImmExt = '0;
        case (ImmSrc)
            IMM_I: ImmExt = {{20{Imm[24]}}, Imm[24:13]};
            IMM_S: ImmExt = {{20{Imm[24]}}, Imm[24:18], Imm[4:0]};
            IMM_B: ImmExt = {{20{Imm[24]}}, Imm[0], Imm[23:18], Imm[4:1], 1'b0};
            IMM_J: ImmExt = {{12{Imm[24]}}, Imm[12:5], Imm[13], Imm[23:14], 1'b0};
            IMM_U: ImmExt = {Imm[24:5], 12'b0};
            default: ImmExt = '0;
        endcase
    end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller: opcode decode, ID/EX register, load-use hazard
// stall/flush sequencing and saturating stall/flush counters.
module decode_ctrl
    import riscv_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      InstrD,
    input  logic             ValidD,
    input  logic             PCSrcE,
    output logic [2:0]       ImmSrcD,
    output logic [31:0]      ImmExtE,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic             LoadE,
    output logic             RegWriteE,
    output logic             ValidE,
    output logic             IllegalE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    imm_src_t    imm_src;
    logic        use1, use2, reg_write, load, illegal;
    logic [31:0] imm_ext;
    logic [4:0]  rs1, rs2, rd;
    logic        hazard, flush_e;

    assign rs1 = InstrD[19:15];
    assign rs2 = InstrD[24:20];
    assign rd  = InstrD[11:7];

    always_comb begin
        imm_src   = IMM_I;
        use1      = 1'b0;
        use2      = 1'b0;
        reg_write = 1'b0;
        load      = 1'b0;
        illegal   = 1'b0;
        case (InstrD[6:0])
            OP_LOAD: begin
                use1 = 1'b1; reg_write = 1'b1; load = 1'b1;
            end
            OP_IMM, OP_JALR: begin
                use1 = 1'b1; reg_write = 1'b1;
            end
            OP_STORE: begin
                imm_src = IMM_S; use1 = 1'b1; use2 = 1'b1;
            end
            OP_BRANCH: begin
                imm_src = IMM_B; use1 = 1'b1; use2 = 1'b1;
            end
            OP_JAL: begin
                imm_src = IMM_J; reg_write = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm_src = IMM_U; reg_write = 1'b1;
            end
            OP_R: begin
                use1 = 1'b1; use2 = 1'b1; reg_write = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign ImmSrcD = imm_src;

    sign_ext u_sign_ext (
        .Imm    (InstrD[31:7]),
        .ImmSrc (imm_src),
        .ImmExt (imm_ext)
    );

    assign hazard = ValidD & ValidE & LoadE & (RdE != 5'd0) &
                    ((use1 & (rs1 == RdE)) | (use2 & (rs2 == RdE)));

    // A redirect discards the D instruction anyway, so it wins over the stall.
    assign StallF  = hazard & ~PCSrcE;
    assign StallD  = hazard & ~PCSrcE;
    assign FlushD  = PCSrcE;
    assign flush_e = hazard | PCSrcE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ImmExtE   <= '0;
            Rs1E      <= '0;
            Rs2E      <= '0;
            RdE       <= '0;
            LoadE     <= 1'b0;
            RegWriteE <= 1'b0;
            ValidE    <= 1'b0;
            IllegalE  <= 1'b0;
        end else if (flush_e || !ValidD) begin
            ImmExtE   <= '0;
            Rs1E      <= '0;
            Rs2E      <= '0;
            RdE       <= '0;
            LoadE     <= 1'b0;
            RegWriteE <= 1'b0;
            ValidE    <= 1'b0;
            IllegalE  <= 1'b0;
        end else begin
            ImmExtE   <= imm_ext;
            Rs1E      <= rs1;
            Rs2E      <= rs2;
            RdE       <= rd;
            LoadE     <= load;
            RegWriteE <= reg_write;
            ValidE    <= 1'b1;
            IllegalE  <= illegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallD && (StallCnt != {CNT_W{1'b1}}))
                StallCnt <= StallCnt + CNT_W'(1);
            if (PCSrcE && (FlushCnt != {CNT_W{1'b1}}))
                FlushCnt <= FlushCnt + CNT_W'(1);
        end
    end

endmodule
